// File: rtl/uart_rx_framer.sv
// Byte-stream framer: SYNC, LEN, payload, XOR checksum. A payload is streamed
// out only after its checksum matches, so downstream never sees a bad frame.
module uart_rx_framer #(
  parameter logic [7:0] SYNC    = 8'h55,
  parameter int         MAXLEN  = 16,
  parameter int         TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [0:15];
  logic [3:0]    r_wr_ptr;
  logic [3:0]    r_rd_ptr;
  logic [4:0]    r_len;
  logic [7:0]    r_chk;
  logic [IW-1:0] r_idle;
  logic [7:0]    r_m_data;
  logic          r_m_valid, r_m_last;
  logic          r_pkt_ok, r_err_chk, r_err_len, r_err_timeout, r_err_overrun;

  logic          w_armed, w_len_bad, w_last_wr, w_xfer, w_wr_en;
  logic [3:0]    w_rd_next, w_len_m1;

  assign w_armed   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  assign w_len_bad = (rx_byte == 8'd0) || (rx_byte > 8'(MAXLEN));
  assign w_len_m1  = 4'(r_len - 5'd1);
  assign w_last_wr = (r_wr_ptr == w_len_m1);
  assign w_xfer    = r_m_valid && m_ready;
  assign w_wr_en   = (r_state == S_PAYLOAD) && rx_valid;
  assign w_rd_next = r_rd_ptr + 4'd1;

  // Payload storage has no reset so it maps onto a RAM primitive.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_len         <= '0;
      r_chk         <= '0;
      r_idle        <= '0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_pkt_ok      <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_pkt_ok      <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
      // An arriving byte always beats the idle limit in the same cycle.
      if (w_armed && !rx_valid) begin
        if (r_idle == IW'(TIMEOUT - 2)) begin
          r_err_timeout <= 1'b1;
          r_idle        <= '0;
          r_state       <= S_IDLE;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end else begin
        r_idle <= '0;
        case (r_state)
          S_IDLE: begin
            if (rx_valid && rx_byte == SYNC) r_state <= S_LEN;
          end
          S_LEN: begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_len    <= rx_byte[4:0];
              r_chk    <= rx_byte;
              r_wr_ptr <= '0;
              r_state  <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_chk    <= r_chk ^ rx_byte;
            r_wr_ptr <= r_wr_ptr + 4'd1;
            if (w_last_wr) r_state <= S_CHK;
          end
          S_CHK: begin
            if (rx_byte == r_chk) begin
              r_pkt_ok  <= 1'b1;
              r_m_valid <= 1'b1;
              r_m_data  <= r_mem[4'd0];
              r_m_last  <= (r_len == 5'd1);
              r_rd_ptr  <= '0;
              r_state   <= S_DRAIN;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          S_DRAIN: begin
            if (rx_valid) r_err_overrun <= 1'b1;
            if (w_xfer) begin
              if (r_m_last) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_state   <= S_IDLE;
              end else begin
                r_rd_ptr <= w_rd_next;
                r_m_data <= r_mem[w_rd_next];
                r_m_last <= (w_rd_next == w_len_m1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign m_last      = r_m_last;
  assign pkt_ok      = r_pkt_ok;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: a table of whole frames plus hand-written
// sequences for idle timeout, backpressure/overrun and mid-frame reset.
module tb_uart_rx_framer;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       m_last;
  logic       pkt_ok, err_chk, err_len, err_timeout, err_overrun;

  uart_rx_framer #(.SYNC(8'h55), .MAXLEN(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pkt_ok(pkt_ok), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         n;
    logic [7:0] b [0:19];
    int         np;
    logic [7:0] p [0:15];
    int         exp_ok, exp_chk, exp_len;
  } vec_t;

  vec_t       tbl [0:9];
  int         nv = 0;
  int         n_checks = 0, n_err = 0;
  int         n_ok, n_chk, n_len, n_to, n_ovr;
  logic [8:0] obs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_ok = 0; n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0;
    obs.delete();
  endtask

  // One clock: log a handshake seen before the edge, then pulses after it.
  task automatic tick();
    if (m_valid && m_ready) obs.push_back({m_last, m_data});
    @(posedge clk);
    #1;
    if (pkt_ok)      n_ok++;
    if (err_chk)     n_chk++;
    if (err_len)     n_len++;
    if (err_timeout) n_to++;
    if (err_overrun) n_ovr++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic add_vec(input bq_t s, input bq_t p, input int ok, input int ck, input int ln);
    tbl[nv].n  = s.size();
    tbl[nv].np = p.size();
    for (int i = 0; i < s.size(); i++) tbl[nv].b[i] = s[i];
    for (int i = 0; i < p.size(); i++) tbl[nv].p[i] = p[i];
    tbl[nv].exp_ok = ok; tbl[nv].exp_chk = ck; tbl[nv].exp_len = ln;
    nv++;
  endtask

  task automatic check_stream(input string nm, input bq_t p);
    check($sformatf("%s_count", nm), obs.size(), p.size());
    for (int j = 0; j < p.size() && j < obs.size(); j++) begin
      check($sformatf("%s_data%0d", nm, j), obs[j][7:0], p[j]);
      check($sformatf("%s_last%0d", nm, j), obs[j][8], (j == p.size() - 1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bq_t s, p;
    // Frame table: bytes in, expected payload and status pulse counts.
    s = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; p = '{8'h11, 8'h22, 8'h33}; add_vec(s, p, 1, 0, 0);
    s = '{8'h55, 8'h02, 8'hAA, 8'hBB, 8'h00};        p.delete();                 add_vec(s, p, 0, 1, 0);
    s = '{8'h55, 8'h00};                             p.delete();                 add_vec(s, p, 0, 0, 1);
    s = '{8'h55, 8'h11};                             p.delete();                 add_vec(s, p, 0, 0, 1);
    s = '{8'h55, 8'h01, 8'h55, 8'h54};               p = '{8'h55};               add_vec(s, p, 1, 0, 0);
    s = '{8'h00, 8'hAA, 8'h55, 8'h55};               p.delete();                 add_vec(s, p, 0, 0, 1);
    s = '{8'h55, 8'h02, 8'h55, 8'h55, 8'h02};        p = '{8'h55, 8'h55};        add_vec(s, p, 1, 0, 0);
    s = '{8'h55, 8'h10};                             p.delete();
    for (int i = 0; i < 16; i++) begin s.push_back(8'(i)); p.push_back(8'(i)); end
    s.push_back(8'h10);                                                          add_vec(s, p, 1, 0, 0);

    rst = 1'b1; tick(); tick();
    check("reset_outputs", {m_data, m_valid, m_last, pkt_ok, err_chk, err_len, err_timeout, err_overrun}, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < nv; v++) begin
      clear_mon();
      m_ready = 1'b1;
      for (int i = 0; i < tbl[v].n; i++) send(tbl[v].b[i]);
      repeat (40) tick();
      check($sformatf("v%0d_pkt_ok", v), n_ok, tbl[v].exp_ok);
      check($sformatf("v%0d_err_chk", v), n_chk, tbl[v].exp_chk);
      check($sformatf("v%0d_err_len", v), n_len, tbl[v].exp_len);
      check($sformatf("v%0d_other_err", v), n_to + n_ovr, 0);
      p.delete();
      for (int j = 0; j < tbl[v].np; j++) p.push_back(tbl[v].p[j]);
      check_stream($sformatf("v%0d", v), p);
    end

    // Idle timeout: pulse appears after exactly TO-1 idle cycles.
    clear_mon();
    send(8'h55); send(8'h04); send(8'h01); send(8'h02);
    for (int k = 1; k < TO - 1; k++) tick();
    check("to_early", n_to, 0);
    tick();
    check("to_pulse", err_timeout, 1);
    tick();
    check("to_width", err_timeout, 0);
    send(8'h55); send(8'h01); send(8'h09); send(8'h08);
    repeat (10) tick();
    check("to_count", n_to, 1);
    check("to_recover_ok", n_ok, 1);
    p = '{8'h09}; check_stream("to_recover", p);

    // A byte landing in the timeout cycle wins.
    clear_mon();
    send(8'h55); send(8'h02); send(8'hC3);
    repeat (TO - 2) tick();
    send(8'h3C);
    repeat (TO - 2) tick();
    send(8'hFD);
    repeat (10) tick();
    check("win_timeout", n_to, 0);
    check("win_ok", n_ok, 1);
    p = '{8'hC3, 8'h3C}; check_stream("win", p);

    // Backpressure with an overrun byte in the stall window.
    clear_mon();
    m_ready = 1'b0;
    send(8'h55); send(8'h02); send(8'hA1); send(8'hB2); send(8'h11);
    check("bp_pkt_ok", pkt_ok, 1);
    check("bp_first_valid", m_valid, 1);
    check("bp_first_data", m_data, 8'hA1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        send(8'h77);
        check("bp_overrun_pulse", err_overrun, 1);
      end else begin
        tick();
      end
      check($sformatf("bp_hold%0d", c), {m_valid, m_last, m_data}, {2'b10, 8'hA1});
    end
    m_ready = 1'b1;
    repeat (6) tick();
    check("bp_overrun_count", n_ovr, 1);
    check("bp_idle_after", m_valid, 0);
    p = '{8'hA1, 8'hB2}; check_stream("bp", p);

    // Reset mid-payload abandons the frame; SYNC accepted straight after.
    clear_mon();
    send(8'h55); send(8'h03); send(8'h01); send(8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_reset_outputs", {m_valid, pkt_ok, err_chk, err_len, err_timeout, err_overrun}, 32'h0);
    send(8'h55); send(8'h02); send(8'h07); send(8'h08); send(8'h0D);
    repeat (10) tick();
    check("mid_reset_ok", n_ok, 1);
    check("mid_reset_errs", n_chk + n_len + n_to + n_ovr, 0);
    p = '{8'h07, 8'h08}; check_stream("mid_reset", p);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have parameter SYNC, default 8'h55, the frame start byte.
REQ-002 The block SHALL have parameter MAXLEN, default 16, the maximum payload length in bytes (range 1..16).
REQ-003 The block SHALL have parameter TIMEOUT, default 50000, the inter-byte idle limit in clk cycles.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 The block SHALL have port rx_byte, input, 8, the received byte from the UART receiver.
REQ-007 The block SHALL have port rx_valid, input, 1, a one-cycle strobe; rx_byte is valid in that cycle.
REQ-008 The block SHALL have port m_data, output, 8, the payload byte.
REQ-009 The block SHALL have port m_valid, output, 1, qualifies m_data.
REQ-010 The block SHALL have port m_ready, input, 1, the downstream accept; a transfer occurs when m_valid and m_ready are both 1.
REQ-011 The block SHALL have port m_last, output, 1, high with the final payload byte.
REQ-012 The block SHALL have ports pkt_ok, err_chk, err_len, err_timeout and err_overrun, each output, 1, a one-cycle status pulse.

Function
REQ-013 Frame format SHALL be: SYNC, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-014 States SHALL be IDLE, LEN, PAYLOAD, CHK and DRAIN, with one transition at most per clk.
REQ-015 In IDLE, the block SHALL move to LEN on rx_valid with rx_byte==SYNC; it SHALL ignore other bytes silently.
REQ-016 In LEN, when rx_valid is high, LEN==0 or LEN>MAXLEN SHALL pulse err_len and return to IDLE.
REQ-017 In LEN, when rx_valid is high and LEN is valid, the block SHALL latch LEN, seed the running XOR with LEN, clear the write pointer, and go to PAYLOAD.
REQ-018 In PAYLOAD, each rx_valid SHALL write rx_byte to buf[wr_ptr] (16x8 storage), XOR it into the running checksum, and increment wr_ptr.
REQ-019 In PAYLOAD, the block SHALL go to CHK after byte number LEN is written.
REQ-020 In CHK, on rx_valid with a match, the block SHALL go to DRAIN and register pkt_ok=1; pkt_ok and m_valid SHALL both first be high in the following cycle.
REQ-021 In CHK, on rx_valid with a mismatch, the block SHALL pulse err_chk, discard the payload, and return to IDLE with no m_valid.
REQ-022 A SYNC value received inside LEN, PAYLOAD or CHK SHALL be treated as data, not as a restart.
REQ-023 In LEN, PAYLOAD and CHK, an idle counter SHALL clear on every rx_valid and increment otherwise.
REQ-024 When the idle counter reaches TIMEOUT-1, the block SHALL pulse err_timeout and return to IDLE.
REQ-025 When rx_valid and the timeout occur in the same cycle, the byte SHALL win and the timeout SHALL NOT fire.
REQ-026 In DRAIN, m_valid SHALL be 1 and m_data SHALL be buf[rd_ptr], starting from rd_ptr=0.
REQ-027 In DRAIN, m_last SHALL be 1 when rd_ptr==LEN-1.
REQ-028 In DRAIN, each transfer SHALL increment rd_ptr.
REQ-029 In DRAIN, a transfer with m_last SHALL return the block to IDLE in the next cycle with m_valid=0.
REQ-030 m_data, m_valid and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-031 Any rx_valid in DRAIN SHALL drop the byte and pulse err_overrun the next cycle, with no state change.
REQ-032 Every status pulse SHALL be registered, one cycle wide, and mutually exclusive per cycle.

Reset
REQ-033 While rst=1, the block SHALL set state=IDLE, clear all pointers, counters and the checksum, and drive m_valid, m_last, m_data, pkt_ok and all err_* outputs to 0.
REQ-034 Reset mid-frame or mid-DRAIN SHALL abandon the frame; buffer contents need not be cleared.
REQ-035 After rst=1, the first cycle with rst=0 SHALL accept a SYNC byte.

Verification
REQ-036 Sending 55 03 11 22 33 03 with m_ready=1 SHALL give one pkt_ok pulse and the stream 11, 22, 33, with m_last only on 33.
REQ-037 Sending 55 02 AA BB 00 SHALL give err_chk=1 once and m_valid SHALL never assert.
REQ-038 Sending 55 00 and then 55 11 (MAXLEN=16) SHALL give err_len twice, after which a valid frame SHALL be accepted.
REQ-039 Sending 55 04 01 02 and then idling TIMEOUT cycles SHALL give err_timeout once in cycle TIMEOUT-1 after the last byte, and SHALL return the block to IDLE.
REQ-040 A valid 2-byte frame with m_ready=0 for 10 cycles SHALL hold m_data=first byte; a byte injected in that window SHALL pulse err_overrun, and both payload bytes SHALL be delivered after m_ready=1.
REQ-041 rst=1 asserted mid-PAYLOAD, followed by a full valid frame, SHALL deliver only the second frame's payload.
